// File: rtl/reg_scoreboard.sv
// Register-file scoreboard: per-register pending-write counters, decode stall/issue control and
// stall statistics. Define REG_SCOREBOARD_BYPASS_EN to let a dependent read issue in the wb cycle.
module reg_scoreboard #(
  parameter int unsigned NREG   = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [SEL_W-1:0]  rs_sel,
  input  logic              rs_used,
  input  logic [SEL_W-1:0]  rt_sel,
  input  logic              rt_used,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_wr,
  input  logic              wb_valid,
  input  logic [SEL_W-1:0]  wb_sel,
  output logic              issue,
  output logic              stall,
  output logic [NREG-1:0]   busy_vec,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] stall_events,
  output logic              err
);

  typedef enum logic [0:0] {StRun, StStalled} state_e;

  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [PERF_W-1:0] PerfMax = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  pend_q [NREG];
  logic [CNT_W-1:0]  pend_d [NREG];
  logic [PERF_W-1:0] cycles_q, cycles_d;
  logic [PERF_W-1:0] events_q, events_d;
  logic              err_q, err_d;

  logic              rs_byp, rt_byp, hazard;
  logic [NREG-1:0]   inc_vec, dec_vec;

  always_comb begin
`ifdef REG_SCOREBOARD_BYPASS_EN
    // Last outstanding write retiring now; the register file forwards it to the read port.
    rs_byp = wb_valid && (wb_sel == rs_sel) && (pend_q[rs_sel] == CNT_W'(1));
    rt_byp = wb_valid && (wb_sel == rt_sel) && (pend_q[rt_sel] == CNT_W'(1));
`else
    rs_byp = 1'b0;
    rt_byp = 1'b0;
`endif
    hazard = (rs_used && (pend_q[rs_sel] != '0) && !rs_byp)
          || (rt_used && (pend_q[rt_sel] != '0) && !rt_byp)
          || (rd_wr && (pend_q[rd_sel] == CntMax));
    issue  = dec_valid && !hazard;
    stall  = dec_valid && hazard;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      pend_d[i]   = pend_q[i];
      busy_vec[i] = (pend_q[i] != '0);
      inc_vec[i]  = issue && rd_wr && (rd_sel == SEL_W'(i));
      dec_vec[i]  = wb_valid && (wb_sel == SEL_W'(i)) && (pend_q[i] != '0);
      if (inc_vec[i] && !dec_vec[i]) begin
        pend_d[i] = pend_q[i] + CNT_W'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        pend_d[i] = pend_q[i] - CNT_W'(1);
      end
    end
    err_d = err_q | (wb_valid && (pend_q[wb_sel] == '0));
  end

  always_comb begin
    state_d  = state_q;
    events_d = events_q;
    cycles_d = cycles_q;
    if (stall && (cycles_q != PerfMax)) begin
      cycles_d = cycles_q + PERF_W'(1);
    end
    unique case (state_q)
      StRun: begin
        if (stall) begin
          state_d = StStalled;
          if (events_q != PerfMax) begin
            events_d = events_q + PERF_W'(1);
          end
        end
      end
      StStalled: begin
        if (!stall) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        pend_q[i] <= '0;
      end
      state_q  <= StRun;
      cycles_q <= '0;
      events_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        pend_q[i] <= pend_d[i];
      end
      state_q  <= state_d;
      cycles_q <= cycles_d;
      events_q <= events_d;
      err_q    <= err_d;
    end
  end

  assign stall_cycles = cycles_q;
  assign stall_events = events_q;
  assign err          = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard; expectations follow REG_SCOREBOARD_BYPASS_EN when defined.
module tb_reg_scoreboard;

`ifdef REG_SCOREBOARD_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid, rs_used, rt_used, rd_wr, wb_valid;
  logic [2:0]  rs_sel, rt_sel, rd_sel, wb_sel;
  logic        issue, stall, err;
  logic [7:0]  busy_vec;
  logic [15:0] stall_cycles, stall_events;

  int n_checks = 0;
  int n_fail   = 0;
  int c_exp    = 0;
  int e_exp    = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid   (dec_valid),
    .rs_sel      (rs_sel),
    .rs_used     (rs_used),
    .rt_sel      (rt_sel),
    .rt_used     (rt_used),
    .rd_sel      (rd_sel),
    .rd_wr       (rd_wr),
    .wb_valid    (wb_valid),
    .wb_sel      (wb_sel),
    .issue       (issue),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .stall_cycles(stall_cycles),
    .stall_events(stall_events),
    .err         (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply a decode/writeback vector and let combinational outputs settle.
  task automatic drive(input logic dv, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                       input logic rdw, input logic wbv, input logic [2:0] wbs);
    dec_valid = dv;  rs_sel = rs;  rs_used = rsu;  rt_sel = rt;  rt_used = rtu;
    rd_sel = rd;  rd_wr = rdw;  wb_valid = wbv;  wb_sel = wbs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drive(1, 3'd1, 1, 3'd0, 0, 3'd0, 0, 0, 3'd0);
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_issue", 32'(issue), 32'd1);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_busy", 32'(busy_vec), 32'h0);
    check_eq("rst_cycles", 32'(stall_cycles), 32'd0);
    check_eq("rst_events", 32'(stall_events), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    rst = 1'b1;

    // Basic issue with rd=2
    drive(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 0, 3'd0);
    check_eq("t1_issue", 32'(issue), 32'd1);
    check_eq("t1_stall", 32'(stall), 32'd0);
    tick();
    check_eq("t1_busy", 32'(busy_vec), 32'h04);
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 3'd2);
    tick();
    check_eq("t1_drain", 32'(busy_vec), 32'h00);

    // RAW on r3, released by writeback
    drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 0, 3'd0);
    tick();
    drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 3'd0);
    check_eq("t2_stall", 32'(stall), 32'd1);
    check_eq("t2_noissue", 32'(issue), 32'd0);
    tick();
    c_exp = 1;  e_exp = 1;
    check_eq("t2_events", 32'(stall_events), 32'(e_exp));
    drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 1, 3'd3);
    check_eq("t2_wb_issue", 32'(issue), 32'(Byp));
    check_eq("t2_wb_stall", 32'(stall), 32'(!Byp));
    tick();
    c_exp = Byp ? 1 : 2;
    drive(1, 3'd3, 1, 3'd0, 0, 3'd0, 0, 0, 3'd0);
    check_eq("t2_post_issue", 32'(issue), 32'd1);
    tick();
    check_eq("t2_cycles", 32'(stall_cycles), 32'(c_exp));
    check_eq("t2_events2", 32'(stall_events), 32'(e_exp));

    // Saturate r5 with three outstanding writes
    repeat (3) begin
      drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 3'd0);
      tick();
    end
    check_eq("t3_busy", 32'(busy_vec), 32'h20);
    drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 3'd0);
    check_eq("t3_sat_stall", 32'(stall), 32'd1);
    tick();
    c_exp++;  e_exp++;
    drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 1, 3'd5);
    check_eq("t3_wb_stall", 32'(stall), 32'd1);
    tick();
    c_exp++;
    drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 3'd0);
    check_eq("t3_issue", 32'(issue), 32'd1);
    tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd5, 1, 0, 3'd0);
    check_eq("t3_resat", 32'(stall), 32'd1);
    repeat (3) begin
      drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 3'd5);
      tick();
    end
    check_eq("t3_drain", 32'(busy_vec), 32'h00);
    check_eq("t3_cycles", 32'(stall_cycles), 32'(c_exp));
    check_eq("t3_events", 32'(stall_events), 32'(e_exp));

    // Same-cycle issue and writeback on r4
    drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 3'd0);
    tick();
    drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 1, 3'd4);
    check_eq("t4_issue", 32'(issue), 32'd1);
    tick();
    check_eq("t4_busy", 32'(busy_vec), 32'h10);
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 3'd4);
    tick();
    check_eq("t4_drain", 32'(busy_vec), 32'h00);
    check_eq("t4_err", 32'(err), 32'd0);

    // Spurious writeback to r6
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 1, 3'd6);
    tick();
    check_eq("t5_err", 32'(err), 32'd1);
    check_eq("t5_busy", 32'(busy_vec), 32'h00);
    drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0);
    tick();
    check_eq("t5_err_held", 32'(err), 32'd1);

    // Long stall on rt port, then async reset mid-stall
    drive(1, 3'd0, 0, 3'd0, 0, 3'd7, 1, 0, 3'd0);
    tick();
    drive(1, 3'd0, 0, 3'd7, 1, 3'd0, 0, 0, 3'd0);
    check_eq("t6_stall", 32'(stall), 32'd1);
    repeat (5) tick();
    c_exp += 5;  e_exp++;
    check_eq("t6_cycles", 32'(stall_cycles), 32'(c_exp));
    check_eq("t6_events", 32'(stall_events), 32'(e_exp));
    rst = 1'b0;
    #1;
    check_eq("t6_rst_issue", 32'(issue), 32'd1);
    check_eq("t6_rst_stall", 32'(stall), 32'd0);
    check_eq("t6_rst_busy", 32'(busy_vec), 32'h00);
    check_eq("t6_rst_cycles", 32'(stall_cycles), 32'd0);
    check_eq("t6_rst_events", 32'(stall_events), 32'd0);
    check_eq("t6_rst_err", 32'(err), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_rel_issue", 32'(issue), 32'd1);
    tick();
    check_eq("t6_rel_cycles", 32'(stall_cycles), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
